// File: rtl/exp_share_arbiter_pkg.sv
// Shared definitions for the exponential-core sharing arbiter.
// Contents: FSM state encoding, Q10.10 format constants, saturation value.
package exp_arb_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StWait
  } arb_state_e;

  // Q10.10 signed fixed-point format of the shared core.
  localparam int unsigned INT_W  = 10;
  localparam int unsigned FRAC_W = 10;
  localparam int unsigned Q_W    = INT_W + FRAC_W;

  // Largest positive Q10.10 value, returned when a job is abandoned.
  localparam logic [Q_W-1:0] SAT_MAX = {1'b0, {(Q_W - 1){1'b1}}};

  // Pointer width for a requester count; kept at least 1 bit wide.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/exp_share_arbiter_if.sv
// Bundle of requester-side and core-side signals of the exponential-core arbiter.
// Modports:
//   master - the arbiter: takes req/req_data and core results, drives grants,
//            responses, status and the core controls.
//   slave  - the environment: requesters plus the shared core.
// Signals:
//   req[NUM_REQ], req_data[NUM_REQ*DATA_WIDTH]  request levels and packed operands
//   gnt[NUM_REQ], rsp_valid[NUM_REQ]            one-cycle one-hot pulses
//   rsp_data[DATA_WIDTH], busy, err             result and status
//   exp_reset, exp_enable, exp_data_in          core controls / operand
//   exp_data_out, exp_done                      core result / completion
interface exp_share_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 20
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          busy;
  logic                          err;
  logic                          exp_reset;
  logic                          exp_enable;
  logic [DATA_WIDTH-1:0]         exp_data_in;
  logic [DATA_WIDTH-1:0]         exp_data_out;
  logic                          exp_done;

  modport master (
    input  req, req_data, exp_data_out, exp_done,
    output gnt, rsp_valid, rsp_data, busy, err, exp_reset, exp_enable, exp_data_in
  );

  modport slave (
    output req, req_data, exp_data_out, exp_done,
    input  gnt, rsp_valid, rsp_data, busy, err, exp_reset, exp_enable, exp_data_in
  );

endinterface

// File: rtl/exp_share_arbiter_rr_arbiter.sv
// Combinational round-robin select: picks the first asserted request at or after
// the pointer, wrapping modulo NUM_REQ.
// Ports:
//   req   in  NUM_REQ  request vector
//   ptr   in  PtrW     highest-priority index
//   gnt   out NUM_REQ  one-hot winner (all zero when nothing requests)
//   idx   out PtrW     binary index of the winner
//   valid out 1        some request was selected
module rr_arbiter
  import exp_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]            req,
  input  logic [ptr_width(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [ptr_width(NUM_REQ)-1:0] idx,
  output logic                          valid
);

  localparam int unsigned PtrW = ptr_width(NUM_REQ);

  int unsigned cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(ptr) + k) % NUM_REQ;
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = PtrW'(cand);
      end
    end
  end

endmodule

// File: rtl/exp_share_arbiter.sv
// Shares one exponential core among NUM_REQ requesters. A round-robin winner's
// operand is latched and presented to the core; the core result is returned to
// that owner with a one-cycle rsp_valid pulse. All outputs are registered.
// Optional feature: define EXP_ARB_TIMEOUT_EN to add a WAIT watchdog that
// abandons a job after TIMEOUT_CYCLES, returns the saturated maximum and sets
// the sticky err flag. Without it err is tied 0 and no counter is built.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-high reset
//   bus    master modport of exp_share_arbiter_if (requesters + core)
module exp_share_arbiter
  import exp_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = 20,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                 clk,
  input logic                 reset,
  exp_share_arbiter_if.master bus
);

  localparam int unsigned PtrW = ptr_width(NUM_REQ);
  localparam logic [DATA_WIDTH-1:0] SatMax = {1'b0, {(DATA_WIDTH - 1){1'b1}}};

  arb_state_e            state_q, state_d;
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [PtrW-1:0]       owner_q, owner_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  busy_q, busy_d;
  logic                  exp_reset_q, exp_reset_d;
  logic                  exp_enable_q, exp_enable_d;
  logic [DATA_WIDTH-1:0] exp_data_in_q, exp_data_in_d;

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [PtrW-1:0]       arb_idx;
  logic                  arb_valid;

`ifdef EXP_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  err_q, err_d;
`else
  logic                  unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req   (bus.req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    gnt_d         = '0;
    rsp_valid_d   = '0;
    rsp_data_d    = rsp_data_q;
    busy_d        = busy_q;
    exp_reset_d   = exp_reset_q;
    exp_enable_d  = exp_enable_q;
    exp_data_in_d = exp_data_in_q;
`ifdef EXP_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    err_d         = err_q;
`endif

    case (state_q)
      StIdle: begin
        exp_reset_d  = 1'b1;
        exp_enable_d = 1'b0;
        busy_d       = 1'b0;
        if (arb_valid) begin
          gnt_d         = arb_gnt;
          exp_data_in_d = bus.req_data[arb_idx * DATA_WIDTH +: DATA_WIDTH];
          owner_d       = arb_idx;
          exp_reset_d   = 1'b0;
          exp_enable_d  = 1'b1;
          busy_d        = 1'b1;
          ptr_d         = (arb_idx == PtrW'(NUM_REQ - 1)) ? '0 : arb_idx + PtrW'(1);
          state_d       = StWait;
`ifdef EXP_ARB_TIMEOUT_EN
          cnt_d         = '0;
`endif
        end
      end

      StWait: begin
        // Completion has priority over a watchdog expiry on the same edge.
        if (bus.exp_done) begin
          rsp_data_d           = bus.exp_data_out;
          rsp_valid_d[owner_q] = 1'b1;
          exp_enable_d         = 1'b0;
          exp_reset_d          = 1'b1;
          busy_d               = 1'b0;
          state_d              = StIdle;
        end
`ifdef EXP_ARB_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          rsp_data_d           = SatMax;
          rsp_valid_d[owner_q] = 1'b1;
          err_d                = 1'b1;
          exp_enable_d         = 1'b0;
          exp_reset_d          = 1'b1;
          busy_d               = 1'b0;
          state_d              = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      owner_q       <= '0;
      gnt_q         <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      busy_q        <= 1'b0;
      exp_reset_q   <= 1'b1;
      exp_enable_q  <= 1'b0;
      exp_data_in_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      gnt_q         <= gnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      busy_q        <= busy_d;
      exp_reset_q   <= exp_reset_d;
      exp_enable_q  <= exp_enable_d;
      exp_data_in_q <= exp_data_in_d;
    end
  end

`ifdef EXP_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // Unused while SatMax only feeds the watchdog path.
  logic unused_sat;
  assign unused_sat = ^SatMax;

  assign bus.gnt         = gnt_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.busy        = busy_q;
  assign bus.exp_reset   = exp_reset_q;
  assign bus.exp_enable  = exp_enable_q;
  assign bus.exp_data_in = exp_data_in_q;

endmodule
